// File: rtl/vec_pkg.sv
// Shared definitions for the vector store path: lane geometry, the
// vector container type and the serializer state encoding.
package vec_pkg;

    localparam int LANES  = 16;
    localparam int WIDTH  = 16;
    localparam int ADDR_W = 32;
    localparam int STEP   = WIDTH / 8;

    typedef logic [LANES-1:0][WIDTH-1:0] vector_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STORE = 2'd1,
        DONE  = 2'd2
    } st_t;

endpackage : vec_pkg

// File: rtl/vec_store_serializer.sv
// Vector store serializer: captures one ALU result vector with its base
// address and lane count, then writes the active lanes to scalar memory
// one per cycle, stalling on mem_ready, and pulses done when finished.
// All outputs are decoded from registered state only.
module vec_store_serializer
    import vec_pkg::*;
#(
    parameter int LANES  = vec_pkg::LANES,
    parameter int WIDTH  = vec_pkg::WIDTH,
    parameter int ADDR_W = vec_pkg::ADDR_W,
    parameter int STEP   = WIDTH / 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [LANES-1:0][WIDTH-1:0]       in_data,
    input  logic [ADDR_W-1:0]                 in_base,
    input  logic [$clog2(LANES):0]            in_vlen,
    output logic                              mem_we,
    output logic [ADDR_W-1:0]                 mem_addr,
    output logic [WIDTH-1:0]                  mem_wdata,
    input  logic                              mem_ready,
    output logic                              busy,
    output logic                              done
);

    localparam int IDX_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int VLEN_W = $clog2(LANES) + 1;

    st_t                          state_q;
    st_t                          state_d;
    logic [IDX_W-1:0]             idx_q;
    logic [VLEN_W-1:0]            vlen_q;
    logic [ADDR_W-1:0]            base_q;
    logic [LANES-1:0][WIDTH-1:0]  buf_q;

    logic                         accept;
    logic                         last_lane;
    logic [VLEN_W-1:0]            vlen_clamped;

    // Handshake, clamp and last-lane decode shared by the FSM and datapath
    always_comb begin
        accept       = (state_q == IDLE) && in_valid;
        vlen_clamped = (in_vlen > VLEN_W'(LANES)) ? VLEN_W'(LANES) : in_vlen;
        last_lane    = ({1'b0, idx_q} == (vlen_q - VLEN_W'(1)));
    end

    // State register; reset aborts any store in progress immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: an empty vector skips straight to the done pulse
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (vlen_clamped == '0) ? DONE : STORE;
                end
            end
            STORE: begin
                if (mem_ready && last_lane) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Capture the vector on accept and step the lane index on each accepted write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q  <= '0;
            vlen_q <= '0;
            base_q <= '0;
            buf_q  <= '0;
        end else if (accept) begin
            idx_q  <= '0;
            vlen_q <= vlen_clamped;
            base_q <= in_base;
            buf_q  <= in_data;
        end else if ((state_q == STORE) && mem_ready && !last_lane) begin
            idx_q  <= idx_q + IDX_W'(1);
        end
    end

    // Moore output decode; address and data are held while memory stalls
    always_comb begin
        in_ready  = (state_q == IDLE);
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q == STORE) begin
            mem_we    = 1'b1;
            mem_addr  = base_q + (ADDR_W'(idx_q) * ADDR_W'(STEP));
            mem_wdata = buf_q[idx_q];
        end
    end

endmodule : vec_store_serializer

// File: tb/tb_vec_store_serializer.sv
// Directed testbench for vec_store_serializer: drives hand-built vectors,
// watches the memory write stream cycle by cycle and compares it with
// expected addresses, data and done timing.
module tb_vec_store_serializer;

    logic                   clk;
    logic                   reset;
    logic                   in_valid;
    logic                   in_ready;
    logic [15:0][15:0]      in_data;
    logic [31:0]            in_base;
    logic [4:0]             in_vlen;
    logic                   mem_we;
    logic [31:0]            mem_addr;
    logic [15:0]            mem_wdata;
    logic                   mem_ready;
    logic                   busy;
    logic                   done;

    int checks = 0;
    int errors = 0;

    logic [15:0][15:0]      vec;

    vec_store_serializer dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_base   (in_base),
        .in_vlen   (in_vlen),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .busy      (busy),
        .done      (done)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Wait (bounded) for in_ready, then present a vector across one capture edge
    task automatic applyStimulus(input logic [15:0][15:0] d, input logic [31:0] b, input logic [4:0] vl, input string tag);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) checkOutput({tag, "_ready_timeout"}, 32'd0, 32'd1);
        in_data  = d;
        in_base  = b;
        in_vlen  = vl;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = '1;
        in_base  = 32'hDEAD_BEEF;
        in_vlen  = 5'd0;
    endtask

    // Run one vector and check every write, the done cycle and the return to ready
    task automatic runVector(input logic [15:0][15:0] d, input logic [31:0] b, input logic [4:0] vl,
                             input logic [63:0] stallMask, input int expDone, input string tag);
        int nExp;
        int nWrites;
        int doneAt;
        nExp    = (vl > 5'd16) ? 16 : int'(vl);
        nWrites = 0;
        doneAt  = -1;
        applyStimulus(d, b, vl, tag);
        for (int cyc = 1; cyc <= expDone + 1; cyc++) begin
            mem_ready = !stallMask[cyc];
            @(negedge clk);
            if (cyc == 1) checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
            if (mem_we) begin
                if (nWrites >= nExp) begin
                    checkOutput({tag, "_extra_write"}, 32'(nWrites), 32'(nExp - 1));
                end else begin
                    checkOutput({tag, "_addr"}, mem_addr, b + 32'(2 * nWrites));
                    checkOutput({tag, "_data"}, 32'(mem_wdata), 32'(d[nWrites]));
                    if (mem_ready) nWrites++;
                end
            end
            if (done && doneAt < 0) doneAt = cyc;
            if (cyc == expDone + 1) begin
                checkOutput({tag, "_ready_after"}, 32'(in_ready), 32'd1);
                checkOutput({tag, "_idle_after"}, 32'(busy), 32'd0);
            end
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b1;
        checkOutput({tag, "_nwrites"}, 32'(nWrites), 32'(nExp));
        checkOutput({tag, "_done_cycle"}, 32'(doneAt), 32'(expDone));
    endtask

    initial begin
        int sawDone;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_base   = '0;
        in_vlen   = '0;
        mem_ready = 1'b1;
        vec       = '0;

        #12;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Full vector, no back-pressure
        vec = '0;
        vec[0] = 16'd210; vec[1] = 16'd255; vec[2] = 16'd252; vec[3] = 16'd245;
        vec[4] = 16'd30;  vec[5] = 16'd11;  vec[6] = 16'd102; vec[7] = 16'd25;
        runVector(vec, 32'h100, 5'd16, 64'd0, 17, "full");

        // Partial vector
        vec = '0;
        vec[0] = 16'd4; vec[1] = 16'd12; vec[2] = 16'd200; vec[3] = 16'd77;
        runVector(vec, 32'h40, 5'd3, 64'd0, 4, "partial");

        // Back-pressure in cycles 1 and 2
        vec = '0;
        vec[0] = 16'hA5A5; vec[1] = 16'h1234;
        runVector(vec, 32'h0, 5'd2, 64'b110, 5, "stall");

        // Empty vector
        runVector(vec, 32'h200, 5'd0, 64'd0, 1, "vlen0");

        // Oversized length clamps to all lanes
        for (int i = 0; i < 16; i++) vec[i] = 16'(16'h1000 + i * 16'h0101);
        runVector(vec, 32'h300, 5'd20, 64'd0, 17, "vlen20");

        // Address wrap at the top of the address space
        vec = '0;
        vec[0] = 16'hBEEF; vec[1] = 16'hCAFE;
        runVector(vec, 32'hFFFF_FFFE, 5'd2, 64'd0, 3, "wrap");

        // Reset in the middle of a store
        for (int i = 0; i < 16; i++) vec[i] = 16'(i + 1);
        applyStimulus(vec, 32'h500, 5'd16, "abort");
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("abort_we_before", 32'(mem_we), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("abort_we", 32'(mem_we), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        sawDone = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            if (done || mem_we) sawDone = 1;
        end
        checkOutput("abort_no_done", 32'(sawDone), 32'd0);
        checkOutput("abort_ready_after", 32'(in_ready), 32'd1);

        // A fresh vector after the abort behaves normally
        vec = '0;
        vec[0] = 16'h0042; vec[1] = 16'h0043; vec[2] = 16'h0044;
        runVector(vec, 32'h600, 5'd3, 64'd0, 4, "post_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule : tb_vec_store_serializer

// File: doc/vec_store_serializer.md
Name: vec_store_serializer

Overview:
- Downstream of the vector ALU (16 lanes x 16 bits). Consumes one finished result vector plus a base address and active lane count.
- Writes the active lanes to scalar-width data memory, one lane per cycle, honouring memory back-pressure.
- Signals completion with a one-cycle done pulse, then accepts the next vector.

Parameters:
- LANES, 16, number of vector lanes
- WIDTH, 16, bits per lane
- ADDR_W, 32, memory byte-address width
- STEP, WIDTH/8, byte increment between consecutive lanes

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  input vector offered
- in_ready  out  1  block can accept a vector
- in_data  in  [LANES-1:0][WIDTH-1:0]  result vector from the ALU
- in_base  in  ADDR_W  byte address for lane 0
- in_vlen  in  $clog2(LANES)+1  number of lanes to store (0..LANES)
- mem_we  out  1  memory write request
- mem_addr  out  ADDR_W  write byte address
- mem_wdata  out  WIDTH  write data
- mem_ready  in  1  memory accepts the write this cycle
- busy  out  1  a vector is held (state != IDLE)
- done  out  1  one-cycle pulse after the last lane is accepted

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; lane index, buffer, base and vlen clear to 0.
  - Outputs: in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0.
- States: IDLE, STORE, DONE. All outputs are decoded from registered state (Moore); no input-to-output combinational path.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, capture in_data, in_base and vlen; idx<=0.
  - vlen = min(in_vlen, LANES); in_vlen>LANES is clamped.
  - vlen==0: go to DONE with no memory write. Otherwise go to STORE.
- STORE:
  - in_ready=0, mem_we=1, mem_addr=base+idx*STEP, mem_wdata=buf[idx].
  - mem_ready=1: lane accepted. If idx==vlen-1, go to DONE; else idx<=idx+1.
  - mem_ready=0: hold addr, data and we stable until accepted.
- DONE: done=1, in_ready=0, mem_we=0; next state is IDLE unconditionally.
- Latency with mem_ready tied high and vlen=N:
  - Capture edge at cycle 0.
  - Writes in cycles 1..N.
  - done in cycle N+1.
  - in_ready=1 again in cycle N+2.
  - Each mem_ready=0 cycle adds one cycle.
- Address arithmetic is modulo 2^ADDR_W; base near the top wraps silently.
- Data is stored exactly as captured: unsigned, no transformation. in_data changes after capture have no effect.
- mem_ready outside STORE is ignored.
- in_valid while busy is not accepted; the upstream holds the vector.
- Reset asserted mid-STORE aborts immediately. mem_we drops asynchronously; remaining lanes are discarded and no done pulse is produced.

Decomposition:
- Shared package vec_pkg:
  - LANES, WIDTH constants.
  - typedef vector_t = logic [LANES-1:0][WIDTH-1:0].
  - typedef enum st_t {IDLE, STORE, DONE}.
- No sub-module required. Lane-select mux and address adder stay inline.

Test Plan:
- Full vector, no back-pressure: in_data lanes 0..7 = {210,255,252,245,30,11,102,25}, lanes 8..15=0, base=0x100, vlen=16, mem_ready=1.
  -> 16 writes at 0x100,0x102,...,0x11E with the matching lane data.
  -> done in cycle 17; in_ready high in cycle 18.
- Partial vector: vlen=3, data {4,12,200}, base=0x40.
  -> writes (0x40,4),(0x42,12),(0x44,200) only.
  -> done in cycle 4; no further mem_we.
- Back-pressure: vlen=2, mem_ready low in cycles 1-2, then high.
  -> addr 0x0/data lane0 held stable through cycles 1-3.
  -> lane1 written in cycle 4; done in cycle 5.
- Edge lengths:
  - vlen=0 -> no mem_we; done in cycle 1.
  - vlen=20 -> clamped, exactly 16 writes.
- Address wrap: base=0xFFFF_FFFE, vlen=2, mem_ready=1.
  -> writes at 0xFFFF_FFFE then 0x0000_0000.
- Reset mid-store: vlen=16, reset asserted in cycle 5.
  -> mem_we=0 immediately; busy=0, in_ready=1 after reset release.
  -> no done pulse; a new vector is then accepted normally.
